// File: rtl/conv_output_buffer.sv
// Rescale/saturate stage plus FWFT result FIFO feeding the next layer, with row/column tagging.
// Optional build macro RELU_EN clamps negative outputs to zero after saturation.
module conv_output_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_WIDTH      = 16,
    parameter int FRACTION_SHIFT = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_AW        = 4,
    parameter int OUT_COLS       = 4,
    parameter int OUT_ROWS       = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  conv_done,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [15:0]           out_col,
    output logic [15:0]           out_row,
    output logic                  frame_done,
    output logic                  overflow_err,
    output logic                  count_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX_C =
        {{(DATA_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN_C =
        {{(DATA_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [FIFO_AW:0]   DEPTH_C    = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE_C  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE_C  = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]        LAST_COL_C = 16'(OUT_COLS - 1);
    localparam logic [15:0]        LAST_ROW_C = 16'(OUT_ROWS - 1);
    localparam logic [15:0]        FRAME_LEN_C = 16'(OUT_COLS * OUT_ROWS);

    // Arithmetic shift then clamp to the signed output range (optionally ReLU).
    function automatic logic [OUT_WIDTH-1:0] scale_sat(input logic signed [DATA_WIDTH-1:0] acc);
        logic signed [DATA_WIDTH-1:0] shifted;
        logic [OUT_WIDTH-1:0]         result;
        shifted = acc >>> FRACTION_SHIFT;
        if (shifted > SAT_MAX_C) begin
            result = SAT_MAX_C[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN_C) begin
            result = SAT_MIN_C[OUT_WIDTH-1:0];
        end else begin
            result = shifted[OUT_WIDTH-1:0];
        end
`ifdef RELU_EN
        if (result[OUT_WIDTH-1]) begin
            result = {OUT_WIDTH{1'b0}};
        end
`endif
        return result;
    endfunction

    logic                 stage_valid_r;
    logic                 stage_last_r;
    logic [OUT_WIDTH-1:0] stage_data_r;
    logic [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_r;
    logic [FIFO_AW-1:0]   rd_ptr_r;
    logic [FIFO_AW:0]     count_r;
    logic [FIFO_AW:0]     count_next_s;
    logic                 out_valid_r;
    logic [15:0]          col_r;
    logic [15:0]          row_r;
    logic                 frame_done_r;
    logic                 overflow_err_r;
    logic                 count_err_r;
    logic [15:0]          push_cnt_r;
    logic                 post_last_r;
    state_t               state_r;
    state_t               state_next_s;
    logic                 draining_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 last_push_s;
    logic                 last_elem_s;

    assign full_s      = (count_r == DEPTH_C);
    assign pop_s       = out_valid_r & out_ready;
    assign push_s      = stage_valid_r & (~full_s | pop_s);
    assign drop_s      = stage_valid_r & full_s & ~pop_s;
    assign last_push_s = push_s & stage_last_r;
    assign last_elem_s = (col_r == LAST_COL_C) && (row_r == LAST_ROW_C);

    assign out_valid    = out_valid_r;
    assign out_data     = out_valid_r ? mem_r[rd_ptr_r] : {OUT_WIDTH{1'b0}};
    assign out_col      = col_r;
    assign out_row      = row_r;
    assign frame_done   = frame_done_r;
    assign overflow_err = overflow_err_r;
    assign count_err    = count_err_r;

    // Scale stage: one register between the MA tree and the FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_valid_r <= 1'b0;
            stage_last_r  <= 1'b0;
            stage_data_r  <= {OUT_WIDTH{1'b0}};
        end else begin
            stage_valid_r <= in_valid;
            stage_last_r  <= in_valid & conv_done;
            if (in_valid) begin
                stage_data_r <= scale_sat(in_data);
            end else begin
                stage_data_r <= stage_data_r;
            end
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE_C;
            2'b01:   count_next_s = count_r - CNT_ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers and registered head-valid flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {OUT_WIDTH{1'b0}};
            end
            wr_ptr_r    <= {FIFO_AW{1'b0}};
            rd_ptr_r    <= {FIFO_AW{1'b0}};
            count_r     <= {(FIFO_AW+1){1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= stage_data_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != {(FIFO_AW+1){1'b0}});
        end
    end

    // Output row/column tag advances on every pop; frame_done follows the last element.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_r        <= 16'd0;
            row_r        <= 16'd0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= pop_s & last_elem_s;
            if (pop_s) begin
                if (col_r == LAST_COL_C) begin
                    col_r <= 16'd0;
                    row_r <= (row_r == LAST_ROW_C) ? 16'd0 : row_r + 16'd1;
                end else begin
                    col_r <= col_r + 16'd1;
                end
            end
        end
    end

    // Push counter and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            push_cnt_r     <= 16'd0;
            overflow_err_r <= 1'b0;
            count_err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                push_cnt_r <= stage_last_r ? 16'd0 : push_cnt_r + 16'd1;
            end
            if (drop_s) begin
                overflow_err_r <= 1'b1;
            end
            if ((last_push_s && ((push_cnt_r + 16'd1) != FRAME_LEN_C)) || (conv_done && !in_valid)) begin
                count_err_r <= 1'b1;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame state transitions; a drain overlapped by the next frame returns to COLLECT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (last_push_s) begin
                    state_next_s = DRAIN;
                end else if (in_valid || push_s) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COLLECT: begin
                if (last_push_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            DRAIN: begin
                if (frame_done_r) begin
                    state_next_s = (post_last_r || push_s) ? COLLECT : IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State decode.
    always_comb begin
        draining_s = 1'b0;
        case (state_r)
            DRAIN:   draining_s = 1'b1;
            default: draining_s = 1'b0;
        endcase
    end

    // Remembers that the next frame started pushing while the previous one drains.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            post_last_r <= 1'b0;
        end else if (!draining_s) begin
            post_last_r <= 1'b0;
        end else if (push_s && !stage_last_r) begin
            post_last_r <= 1'b1;
        end else begin
            post_last_r <= post_last_r;
        end
    end

endmodule

// File: tb/tb_conv_output_buffer.sv
// Directed, table-driven self-checking bench for conv_output_buffer.
module tb_conv_output_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        conv_done = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [15:0] out_col;
    logic [15:0] out_row;
    logic        frame_done;
    logic        overflow_err;
    logic        count_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp_out;
        logic        last;
    } vec_t;

    vec_t vecs[$];

    conv_output_buffer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .conv_done(conv_done), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_col(out_col), .out_row(out_row),
        .frame_done(frame_done), .overflow_err(overflow_err), .count_err(count_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        conv_done = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Stream vecs back-to-back with out_ready=1; outputs appear two edges after each input.
    task automatic run_vecs(input logic exp_cerr);
        int n;
        logic exp_v;
        n = vecs.size();
        out_ready = 1'b1;
        for (int c = 0; c < n + 3; c++) begin
            if (c < n) begin
                in_valid = 1'b1;
                in_data = vecs[c].din;
                conv_done = vecs[c].last;
            end else begin
                in_valid = 1'b0;
                conv_done = 1'b0;
            end
            tick();
            exp_v = (c >= 1) && (c <= n);
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                check("out_data", {16'd0, out_data}, {16'd0, vecs[c-1].exp_out});
                check("out_col", {16'd0, out_col}, 32'((c - 1) % 4));
                check("out_row", {16'd0, out_row}, 32'(((c - 1) / 4) % 3));
            end
            check("frame_done", {31'd0, frame_done}, {31'd0, (c >= 2) && (((c - 2) % 12) == 11)});
        end
        in_valid = 1'b0;
        conv_done = 1'b0;
        check("count_err", {31'd0, count_err}, {31'd0, exp_cerr});
    endtask

    task automatic fill_frame(input int last_idx);
        vec_t v;
        vecs.delete();
        for (int k = 1; k <= 12; k++) begin
            v.din = 32'h0000_0100 * 32'(k);
            v.exp_out = 16'(k);
            v.last = (k - 1 == last_idx);
            vecs.push_back(v);
        end
    endtask

    task automatic push_value(input logic [31:0] d);
        in_valid = 1'b1;
        in_data = d;
        conv_done = 1'b0;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [15:0] neg_max;
        logic [15:0] neg_one;
        logic [15:0] neg_small;

        // Reset state
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_col", {16'd0, out_col}, 32'd0);
        check("rst_out_row", {16'd0, out_row}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_overflow", {31'd0, overflow_err}, 32'd0);
        check("rst_count_err", {31'd0, count_err}, 32'd0);

        // Normal 12-result frame
        fill_frame(11);
        run_vecs(1'b0);

        // Saturation / rescale table
        do_reset();
`ifdef RELU_EN
        neg_max = 16'h0000; neg_one = 16'h0000; neg_small = 16'h0000;
`else
        neg_max = 16'h8000; neg_one = 16'hFFFF; neg_small = 16'hFF80;
`endif
        vecs.delete();
        v.last = 1'b0;
        v.din = 32'h7FFF_FFFF; v.exp_out = 16'h7FFF;  vecs.push_back(v);
        v.din = 32'h8000_0000; v.exp_out = neg_max;   vecs.push_back(v);
        v.din = 32'hFFFF_FF00; v.exp_out = neg_one;   vecs.push_back(v);
        v.din = 32'h0001_2345; v.exp_out = 16'h0123;  vecs.push_back(v);
        v.din = 32'hFFFF_8000; v.exp_out = neg_small; vecs.push_back(v);
        v.din = 32'h007F_FFFF; v.exp_out = 16'h7FFF;  vecs.push_back(v);
        run_vecs(1'b0);

        // Backpressure: 17 pushes into a 16-deep FIFO
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            push_value(32'h0000_0100 * 32'(k));
        end
        check("bp_no_overflow_yet", {31'd0, overflow_err}, 32'd0);
        tick();
        check("bp_overflow", {31'd0, overflow_err}, 32'd1);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head_stable", {16'd0, out_data}, 32'd1);
        out_ready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            check("bp_pop_valid", {31'd0, out_valid}, 32'd1);
            check("bp_pop_data", {16'd0, out_data}, 32'(j));
            tick();
        end
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            push_value(32'h0000_0100 * 32'(k));
            if (k == 16) begin
                check("full_no_overflow", {31'd0, overflow_err}, 32'd0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("pp_overflow", {31'd0, overflow_err}, 32'd0);
        check("pp_head", {16'd0, out_data}, 32'd2);
        out_ready = 1'b1;
        for (int j = 2; j <= 17; j++) begin
            check("pp_pop_valid", {31'd0, out_valid}, 32'd1);
            check("pp_pop_data", {16'd0, out_data}, 32'(j));
            tick();
        end
        check("pp_empty", {31'd0, out_valid}, 32'd0);

        // conv_done on the 10th result: count error, frame_done still after 12th pop
        do_reset();
        fill_frame(9);
        run_vecs(1'b1);

        // conv_done without in_valid sets count_err
        do_reset();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        check("lone_conv_done", {31'd0, count_err}, 32'd1);

        // Reset mid-frame, then a clean frame
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            push_value(32'h0000_0100 * 32'(k));
        end
        tick();
        check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {16'd0, out_data}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_frame_done", {31'd0, frame_done}, 32'd0);
        fill_frame(11);
        run_vecs(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
